// File: rtl/id_stage_pkg.sv
// Shared decode constants and types for the ID stage.
// RTL operation codes, operation classes, instruction groups and field values.
package id_stage_pkg;

    localparam int RTLOP_W   = 4;
    localparam int RTLTYPE_W = 2;
    localparam int REG_BUS   = 5;

    localparam logic [REG_BUS-1:0] REG_X0 = 5'd0;

    localparam logic [RTLOP_W-1:0] RTLOP_ADD  = 4'b0000;
    localparam logic [RTLOP_W-1:0] RTLOP_SLL  = 4'b0001;
    localparam logic [RTLOP_W-1:0] RTLOP_SLT  = 4'b0010;
    localparam logic [RTLOP_W-1:0] RTLOP_SLTU = 4'b0011;
    localparam logic [RTLOP_W-1:0] RTLOP_XOR  = 4'b0100;
    localparam logic [RTLOP_W-1:0] RTLOP_SHR  = 4'b0101;
    localparam logic [RTLOP_W-1:0] RTLOP_OR   = 4'b0110;
    localparam logic [RTLOP_W-1:0] RTLOP_AND  = 4'b0111;
    localparam logic [RTLOP_W-1:0] RTLOP_SUB  = 4'b1000;
    localparam logic [RTLOP_W-1:0] RTLOP_SAR  = 4'b1101;

    localparam logic [RTLTYPE_W-1:0] RTLTYPE_ARICH = 2'd0;
    localparam logic [RTLTYPE_W-1:0] RTLTYPE_LOGIC = 2'd1;
    localparam logic [RTLTYPE_W-1:0] RTLTYPE_SHIFT = 2'd2;

    typedef enum logic [6:0] {
        INSTRGROUP_I     = 7'b0010011,
        INSTRGROUP_R     = 7'b0110011,
        INSTRGROUP_LUI   = 7'b0110111,
        INSTRGROUP_AUIPC = 7'b0010111
    } instrgroup_e;

    localparam logic [2:0] FUNCT3_ADD  = 3'b000;
    localparam logic [2:0] FUNCT3_SLL  = 3'b001;
    localparam logic [2:0] FUNCT3_SLT  = 3'b010;
    localparam logic [2:0] FUNCT3_SLTU = 3'b011;
    localparam logic [2:0] FUNCT3_XOR  = 3'b100;
    localparam logic [2:0] FUNCT3_SR   = 3'b101;
    localparam logic [2:0] FUNCT3_OR   = 3'b110;
    localparam logic [2:0] FUNCT3_AND  = 3'b111;

    localparam logic [6:0] FUNCT7_ZERO = 7'b0000000;
    localparam logic [6:0] FUNCT7_SUB  = 7'b0100000;
    localparam logic [6:0] FUNCT7_SAR  = 7'b0100000;

    typedef enum logic [1:0] {
        SRC1_RS,
        SRC1_ZERO,
        SRC1_PC
    } src1_sel_e;

    typedef enum logic [1:0] {
        SRC2_RS,
        SRC2_IMM_I,
        SRC2_IMM_U
    } src2_sel_e;

    function automatic logic [RTLTYPE_W-1:0] rtltype_of(
        input logic [RTLOP_W-1:0] op
    );
        logic [RTLTYPE_W-1:0] t;
        unique case (op)
            RTLOP_SLL, RTLOP_SHR, RTLOP_SAR: t = RTLTYPE_SHIFT;
            RTLOP_XOR, RTLOP_OR, RTLOP_AND:  t = RTLTYPE_LOGIC;
            default:                         t = RTLTYPE_ARICH;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/id_fwd_mux.sv
// Priority forwarding selector for one source operand.
// Lowest index (youngest) matching source wins; x0 is never forwarded.
module id_fwd_mux
    import id_stage_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int FWD_STAGES = 2
) (
    input  logic [REG_BUS-1:0]            rs,
    input  logic [XLEN-1:0]               rf_data,
    input  logic [REG_BUS*FWD_STAGES-1:0] fwd_waddr,
    input  logic [XLEN*FWD_STAGES-1:0]    fwd_wdata,
    input  logic [FWD_STAGES-1:0]         fwd_pending,
    output logic [XLEN-1:0]               data,
    output logic                          pending
);

    logic hit;

    // first matching source decides; a pending winner falls back to RF data
    always_comb begin
        data    = rf_data;
        pending = 1'b0;
        hit     = 1'b0;
        for (int i = 0; i < FWD_STAGES; i++) begin
            if (!hit && rs != REG_X0 &&
                fwd_waddr[i*REG_BUS +: REG_BUS] == rs) begin
                hit     = 1'b1;
                pending = fwd_pending[i];
                if (!fwd_pending[i]) begin
                    data = fwd_wdata[i*XLEN +: XLEN];
                end
            end
        end
        if (rs == REG_X0) begin
            data = '0;
        end
    end

endmodule

// File: rtl/id_stage.sv
// Decode stage for OP-IMM, OP, LUI and AUIPC with operand forwarding.
// Holds the ID/EX slot behind a valid/ready handshake and counts stalls.
module id_stage
    import id_stage_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int FWD_STAGES  = 2,
    parameter int STALL_CNT_W = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [31:0]                   instr_i,
    input  logic [XLEN-1:0]               pc_i,
    output logic [REG_BUS-1:0]            gprs_raddr1,
    output logic [REG_BUS-1:0]            gprs_raddr2,
    input  logic [XLEN-1:0]               gprs_rdata1_i,
    input  logic [XLEN-1:0]               gprs_rdata2_i,
    input  logic [REG_BUS*FWD_STAGES-1:0] fwd_waddr_i,
    input  logic [XLEN*FWD_STAGES-1:0]    fwd_wdata_i,
    input  logic [FWD_STAGES-1:0]         fwd_pending_i,
    input  logic                          flush_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [RTLOP_W-1:0]            rtlop_o,
    output logic [RTLTYPE_W-1:0]          rtltype_o,
    output logic [XLEN-1:0]               pc_o,
    output logic [XLEN-1:0]               src1_o,
    output logic [XLEN-1:0]               src2_o,
    output logic [REG_BUS-1:0]            gprs_waddr_o,
    output logic                          illegal_o,
    output logic                          error_o,
    output logic [STALL_CNT_W-1:0]        stall_cnt_o
);

    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic [REG_BUS-1:0] rd;
    logic [REG_BUS-1:0] rs1;
    logic [REG_BUS-1:0] rs2;
    logic [31:0]        u_imm32;
    logic [XLEN-1:0]    imm_i;
    logic [XLEN-1:0]    imm_u;

    logic               dec_illegal;
    logic               use_rs1;
    logic               use_rs2;
    logic [RTLOP_W-1:0] dec_op;
    src1_sel_e          src1_sel;
    src2_sel_e          src2_sel;

    logic [XLEN-1:0]    op1_data;
    logic [XLEN-1:0]    op2_data;
    logic               op1_pending;
    logic               op2_pending;
    logic [XLEN-1:0]    src1_val;
    logic [XLEN-1:0]    src2_val;

    logic               hazard;
    logic               slot_free;
    logic               xfer;

    assign opcode  = instr_i[6:0];
    assign rd      = instr_i[11:7];
    assign funct3  = instr_i[14:12];
    assign rs1     = instr_i[19:15];
    assign rs2     = instr_i[24:20];
    assign funct7  = instr_i[31:25];
    assign u_imm32 = {instr_i[31:12], 12'b0};
    assign imm_i   = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
    assign imm_u   = {{(XLEN-31){u_imm32[31]}}, u_imm32[30:0]};

    assign gprs_raddr1 = rs1;
    assign gprs_raddr2 = rs2;

    // instruction group and funct field decode
    always_comb begin
        dec_illegal = 1'b0;
        use_rs1     = 1'b0;
        use_rs2     = 1'b0;
        dec_op      = RTLOP_ADD;
        src1_sel    = SRC1_RS;
        src2_sel    = SRC2_RS;
        unique case (1'b1)
            opcode == INSTRGROUP_I: begin
                use_rs1  = 1'b1;
                src2_sel = SRC2_IMM_I;
                dec_op   = {1'b0, funct3};
                if (funct3 == FUNCT3_SLL && funct7 != FUNCT7_ZERO) begin
                    dec_illegal = 1'b1;
                end
                if (funct3 == FUNCT3_SR) begin
                    if (funct7 == FUNCT7_ZERO) begin
                        dec_op = RTLOP_SHR;
                    end else if (funct7 == FUNCT7_SAR) begin
                        dec_op = RTLOP_SAR;
                    end else begin
                        dec_illegal = 1'b1;
                    end
                end
            end
            opcode == INSTRGROUP_R: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                dec_op  = {1'b0, funct3};
                if (funct3 == FUNCT3_ADD) begin
                    if (funct7 == FUNCT7_SUB) begin
                        dec_op = RTLOP_SUB;
                    end else if (funct7 != FUNCT7_ZERO) begin
                        dec_illegal = 1'b1;
                    end
                end else if (funct3 == FUNCT3_SR) begin
                    if (funct7 == FUNCT7_ZERO) begin
                        dec_op = RTLOP_SHR;
                    end else if (funct7 == FUNCT7_SAR) begin
                        dec_op = RTLOP_SAR;
                    end else begin
                        dec_illegal = 1'b1;
                    end
                end else if (funct7 != FUNCT7_ZERO) begin
                    dec_illegal = 1'b1;
                end
            end
            opcode == INSTRGROUP_LUI: begin
                src1_sel = SRC1_ZERO;
                src2_sel = SRC2_IMM_U;
            end
            opcode == INSTRGROUP_AUIPC: begin
                src1_sel = SRC1_PC;
                src2_sel = SRC2_IMM_U;
            end
            default: begin
                dec_illegal = 1'b1;
            end
        endcase
        if (dec_illegal) begin
            dec_op = RTLOP_ADD;
        end
    end

    id_fwd_mux #(
        .XLEN       (XLEN),
        .FWD_STAGES (FWD_STAGES)
    ) u_fwd1 (
        .rs          (rs1),
        .rf_data     (gprs_rdata1_i),
        .fwd_waddr   (fwd_waddr_i),
        .fwd_wdata   (fwd_wdata_i),
        .fwd_pending (fwd_pending_i),
        .data        (op1_data),
        .pending     (op1_pending)
    );

    id_fwd_mux #(
        .XLEN       (XLEN),
        .FWD_STAGES (FWD_STAGES)
    ) u_fwd2 (
        .rs          (rs2),
        .rf_data     (gprs_rdata2_i),
        .fwd_waddr   (fwd_waddr_i),
        .fwd_wdata   (fwd_wdata_i),
        .fwd_pending (fwd_pending_i),
        .data        (op2_data),
        .pending     (op2_pending)
    );

    // operand source selection
    always_comb begin
        unique case (src1_sel)
            SRC1_RS:   src1_val = op1_data;
            SRC1_ZERO: src1_val = '0;
            SRC1_PC:   src1_val = pc_i;
            default:   src1_val = '0;
        endcase
        unique case (src2_sel)
            SRC2_RS:    src2_val = op2_data;
            SRC2_IMM_I: src2_val = imm_i;
            SRC2_IMM_U: src2_val = imm_u;
            default:    src2_val = '0;
        endcase
    end

    assign hazard = in_valid_i &&
                    ((use_rs1 && op1_pending) ||
                     (use_rs2 && op2_pending));

    assign slot_free  = !out_valid_o || out_ready_i;
    assign in_ready_o = slot_free && !hazard && !flush_i;
    assign xfer       = in_valid_i && in_ready_o;

    // ID/EX slot: flush first, then load, then drain when consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_o  <= 1'b0;
            illegal_o    <= 1'b0;
            error_o      <= 1'b0;
            rtlop_o      <= RTLOP_ADD;
            rtltype_o    <= RTLTYPE_ARICH;
            pc_o         <= '0;
            src1_o       <= '0;
            src2_o       <= '0;
            gprs_waddr_o <= REG_X0;
        end else if (flush_i) begin
            out_valid_o <= 1'b0;
            illegal_o   <= 1'b0;
        end else if (xfer) begin
            out_valid_o  <= 1'b1;
            illegal_o    <= dec_illegal;
            rtlop_o      <= dec_op;
            rtltype_o    <= rtltype_of(dec_op);
            pc_o         <= pc_i;
            src1_o       <= src1_val;
            src2_o       <= src2_val;
            gprs_waddr_o <= dec_illegal ? REG_X0 : rd;
            if (dec_illegal) begin
                error_o <= 1'b1;
            end
        end else if (slot_free) begin
            out_valid_o <= 1'b0;
        end
    end

    // saturating count of interlock cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_o <= '0;
        end else if (hazard && !flush_i && stall_cnt_o != '1) begin
            stall_cnt_o <= stall_cnt_o + STALL_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed vectors, corner sequences
// and a randomized run against a behavioural reference model.
module tb_id_stage;
    import id_stage_pkg::*;

    localparam int XL = 32;
    localparam int NF = 2;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   instr;
    logic [31:0]   pc;
    logic [4:0]    raddr1;
    logic [4:0]    raddr2;
    logic [31:0]   rdata1;
    logic [31:0]   rdata2;
    logic [5*NF-1:0]  fwd_waddr;
    logic [32*NF-1:0] fwd_wdata;
    logic [NF-1:0] fwd_pending;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [3:0]    rtlop;
    logic [1:0]    rtltype;
    logic [31:0]   pc_q;
    logic [31:0]   src1;
    logic [31:0]   src2;
    logic [4:0]    waddr;
    logic          illegal;
    logic          error;
    logic [CW-1:0] stall_cnt;

    logic [31:0] regs [32];

    int checks = 0;
    int failures = 0;

    assign rdata1 = regs[raddr1];
    assign rdata2 = regs[raddr2];

    id_stage #(
        .XLEN(XL), .FWD_STAGES(NF), .STALL_CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .instr_i(instr), .pc_i(pc),
        .gprs_raddr1(raddr1), .gprs_raddr2(raddr2),
        .gprs_rdata1_i(rdata1), .gprs_rdata2_i(rdata2),
        .fwd_waddr_i(fwd_waddr), .fwd_wdata_i(fwd_wdata),
        .fwd_pending_i(fwd_pending), .flush_i(flush),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .rtlop_o(rtlop), .rtltype_o(rtltype), .pc_o(pc_q),
        .src1_o(src1), .src2_o(src2), .gprs_waddr_o(waddr),
        .illegal_o(illegal), .error_o(error),
        .stall_cnt_o(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic set_fwd(input int i, input logic [4:0] a,
                           input logic [31:0] d, input logic p);
        fwd_waddr[i*5 +: 5]   = a;
        fwd_wdata[i*32 +: 32] = d;
        fwd_pending[i]        = p;
    endtask

    task automatic clear_fwd();
        for (int i = 0; i < NF; i++) set_fwd(i, 5'd31, 32'h0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic        ill;
        logic        u1;
        logic        u2;
        logic [3:0]  op;
        logic [31:0] imm;
        int          s1;   // 0 register, 1 zero, 2 pc
    } rdec_t;

    function automatic rdec_t ref_decode(input logic [31:0] ins);
        rdec_t d;
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = ins[14:12];
        f7 = ins[31:25];
        d.ill = 1'b0; d.u1 = 1'b0; d.u2 = 1'b0;
        d.op = RTLOP_ADD; d.imm = 32'h0; d.s1 = 0;
        case (ins[6:0])
            7'h13: begin
                d.u1  = 1'b1;
                d.imm = {{20{ins[31]}}, ins[31:20]};
                if (f3 == 3'd5) begin
                    d.ill = !(f7 == 7'h00 || f7 == 7'h20);
                    d.op  = (f7 == 7'h20) ? RTLOP_SAR : RTLOP_SHR;
                end else begin
                    d.ill = (f3 == 3'd1) && (f7 != 7'h00);
                    d.op  = {1'b0, f3};
                end
            end
            7'h33: begin
                d.u1  = 1'b1;
                d.u2  = 1'b1;
                d.ill = !(f7 == 7'h00 ||
                          (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
                if (f7 == 7'h20)
                    d.op = (f3 == 3'd0) ? RTLOP_SUB : RTLOP_SAR;
                else
                    d.op = {1'b0, f3};
            end
            7'h37: begin
                d.s1  = 1;
                d.imm = {ins[31:12], 12'h000};
            end
            7'h17: begin
                d.s1  = 2;
                d.imm = {ins[31:12], 12'h000};
            end
            default: d.ill = 1'b1;
        endcase
        return d;
    endfunction

    function automatic logic [1:0] ref_type(input logic [3:0] op);
        if (op == RTLOP_SLL || op == RTLOP_SHR || op == RTLOP_SAR)
            return RTLTYPE_SHIFT;
        if (op == RTLOP_XOR || op == RTLOP_OR || op == RTLOP_AND)
            return RTLTYPE_LOGIC;
        return RTLTYPE_ARICH;
    endfunction

    // {pending, value} for a register, youngest matching source first
    function automatic logic [32:0] ref_operand(input logic [4:0] rs);
        if (rs == 5'd0) return 33'd0;
        for (int i = 0; i < NF; i++) begin
            if (fwd_waddr[i*5 +: 5] == rs) begin
                if (fwd_pending[i]) return {1'b1, regs[rs]};
                return {1'b0, fwd_wdata[i*32 +: 32]};
            end
        end
        return {1'b0, regs[rs]};
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [6:0] f7;
        logic [4:0] r1, r2, rd;
        logic [2:0] f3;
        int k;
        k  = $urandom_range(0, 3);
        f7 = (k < 2) ? 7'h00 : (k == 2) ? 7'h20 : 7'($urandom);
        r1 = 5'($urandom_range(0, 7));
        r2 = 5'($urandom_range(0, 7));
        rd = 5'($urandom_range(0, 7));
        f3 = 3'($urandom);
        k  = $urandom_range(0, 9);
        if (k < 4) return {f7, r2, r1, f3, rd, 7'h13};
        if (k < 7) return {f7, r2, r1, f3, rd, 7'h33};
        if (k == 7) return {20'($urandom), rd, 7'h37};
        if (k == 8) return {20'($urandom), rd, 7'h17};
        return $urandom;
    endfunction

    // ---------------- directed vectors ----------------
    typedef struct {
        string       nm;
        logic [31:0] ins, pc, v1, v2;
        logic [4:0]  a0; logic [31:0] d0; logic p0;
        logic [4:0]  a1; logic [31:0] d1; logic p1;
        logic [31:0] e1, e2;
        logic [4:0]  ew;
        logic [3:0]  eop;
        logic [1:0]  ety;
        logic        eill;
    } vec_t;

    vec_t vecs [12];

    // model state
    logic        m_valid, m_ill, m_err;
    logic [31:0] m_pc, m_s1, m_s2;
    logic [4:0]  m_waddr;
    logic [3:0]  m_op;
    int          m_cnt;

    initial begin
        rdec_t       d;
        logic [32:0] o1, o2;
        logic        hz, free, rdy;
        int          cnt0;

        rst = 1'b0; in_valid = 1'b0; instr = 32'h0; pc = 32'h0;
        flush = 1'b0; out_ready = 1'b1;
        fwd_waddr = '0; fwd_wdata = '0; fwd_pending = '0;
        for (int i = 0; i < 32; i++) regs[i] = 32'h0;
        clear_fwd();

        vecs[0]  = '{"addi",  32'h00500093, 32'h10, 0, 0,
                     31, 0, 0, 31, 0, 0,
                     32'h0, 32'h5, 1, RTLOP_ADD, RTLTYPE_ARICH, 0};
        vecs[1]  = '{"sub_fwd", 32'h402081B3, 32'h14, 9, 4,
                     1, 7, 0, 31, 0, 0,
                     32'h7, 32'h4, 3, RTLOP_SUB, RTLTYPE_ARICH, 0};
        vecs[2]  = '{"addi_neg", 32'hFFF18113, 32'h18, 10, 0,
                     31, 0, 0, 31, 0, 0,
                     32'hA, 32'hFFFFFFFF, 2, RTLOP_ADD, RTLTYPE_ARICH, 0};
        vecs[3]  = '{"srai_fwd1", 32'h4032D213, 32'h1C, 32'h80, 0,
                     6, 32'h99, 0, 5, 32'h33, 0,
                     32'h33, 32'h403, 4, RTLOP_SAR, RTLTYPE_SHIFT, 0};
        vecs[4]  = '{"slli_bad", 32'h40329213, 32'h20, 0, 0,
                     31, 0, 0, 31, 0, 0,
                     32'h0, 32'h0, 0, RTLOP_ADD, RTLTYPE_ARICH, 1};
        vecs[5]  = '{"lui", 32'h123453B7, 32'h24, 0, 0,
                     31, 0, 0, 31, 0, 0,
                     32'h0, 32'h12345000, 7, RTLOP_ADD, RTLTYPE_ARICH, 0};
        vecs[6]  = '{"auipc", 32'hFFFFF417, 32'h100, 0, 0,
                     31, 0, 0, 31, 0, 0,
                     32'h100, 32'hFFFFF000, 8, RTLOP_ADD, RTLTYPE_ARICH, 0};
        vecs[7]  = '{"xor_fwd2", 32'h0020C4B3, 32'h28, 1, 2,
                     1, 32'h55, 0, 2, 32'hAA, 0,
                     32'h55, 32'hAA, 9, RTLOP_XOR, RTLTYPE_LOGIC, 0};
        vecs[8]  = '{"or_bad", 32'h0220E4B3, 32'h2C, 1, 2,
                     31, 0, 0, 31, 0, 0,
                     32'h0, 32'h0, 0, RTLOP_ADD, RTLTYPE_ARICH, 1};
        vecs[9]  = '{"add_x0", 32'h00000533, 32'h30, 0, 0,
                     0, 32'h99, 0, 0, 32'h98, 1,
                     32'h0, 32'h0, 10, RTLOP_ADD, RTLTYPE_ARICH, 0};
        vecs[10] = '{"sra_fwd1", 32'h4020D5B3, 32'h34, 3, 4,
                     31, 0, 0, 1, 32'h77, 0,
                     32'h77, 32'h4, 11, RTLOP_SAR, RTLTYPE_SHIFT, 0};
        vecs[11] = '{"srl_prio", 32'h0020D633, 32'h38, 5, 6,
                     2, 32'hD0, 0, 2, 32'hD1, 0,
                     32'h5, 32'hD0, 12, RTLOP_SHR, RTLTYPE_ARICH, 0};
        vecs[11].ety = RTLTYPE_SHIFT;

        // reset state
        do_reset();
        chk("rst_valid", out_valid, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_error", error, 0);
        chk("rst_rtlop", rtlop, RTLOP_ADD);
        chk("rst_rtltype", rtltype, RTLTYPE_ARICH);
        chk("rst_pc", pc_q, 0);
        chk("rst_src1", src1, 0);
        chk("rst_src2", src2, 0);
        chk("rst_waddr", waddr, 0);
        chk("rst_cnt", stall_cnt, 0);

        // table-driven single instructions
        for (int v = 0; v < 12; v++) begin
            regs[vecs[v].ins[24:20]] = vecs[v].v2;
            regs[vecs[v].ins[19:15]] = vecs[v].v1;
            regs[0] = 32'h0;
            set_fwd(0, vecs[v].a0, vecs[v].d0, vecs[v].p0);
            set_fwd(1, vecs[v].a1, vecs[v].d1, vecs[v].p1);
            instr = vecs[v].ins;
            pc = vecs[v].pc;
            in_valid = 1'b1;
            out_ready = 1'b1;
            #1;
            chk({vecs[v].nm, "_ready"}, in_ready, 1);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            chk({vecs[v].nm, "_valid"}, out_valid, 1);
            chk({vecs[v].nm, "_ill"}, illegal, vecs[v].eill);
            chk({vecs[v].nm, "_waddr"}, waddr, vecs[v].ew);
            chk({vecs[v].nm, "_pc"}, pc_q, vecs[v].pc);
            if (vecs[v].eill) begin
                chk({vecs[v].nm, "_err"}, error, 1);
            end else begin
                chk({vecs[v].nm, "_src1"}, src1, vecs[v].e1);
                chk({vecs[v].nm, "_src2"}, src2, vecs[v].e2);
                chk({vecs[v].nm, "_op"}, rtlop, vecs[v].eop);
                chk({vecs[v].nm, "_type"}, rtltype, vecs[v].ety);
            end
        end
        clear_fwd();

        // interlock on pending youngest source, then release
        do_reset();
        regs[5] = 32'h44;
        instr = 32'h00028313;
        pc = 32'h200;
        set_fwd(0, 5, 32'hAB, 1'b1);
        set_fwd(1, 5, 32'h3, 1'b0);
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("stall_ready", in_ready, 0);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            chk("stall_cnt", stall_cnt, k);
            chk("stall_valid", out_valid, 0);
        end
        set_fwd(0, 5, 32'h11, 1'b0);
        #1;
        chk("release_ready", in_ready, 1);
        @(posedge clk);
        #1;
        chk("release_valid", out_valid, 1);
        chk("release_src1", src1, 32'h11);
        chk("release_waddr", waddr, 6);
        chk("release_cnt", stall_cnt, 3);

        // flush together with hazard and valid input, slot held
        set_fwd(0, 5, 32'h11, 1'b1);
        flush = 1'b1;
        out_ready = 1'b0;
        #1;
        chk("flush_hz_ready", in_ready, 0);
        cnt0 = int'(stall_cnt);
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_hz_valid", out_valid, 0);
        chk("flush_hz_cnt", stall_cnt, cnt0);
        chk("flush_hz_ill", illegal, 0);

        // counter saturation
        out_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("stall_sat", stall_cnt, 15);
        in_valid = 1'b0;
        clear_fwd();

        // backpressure holds the slot
        do_reset();
        instr = 32'h00500093;
        pc = 32'h300;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        instr = 32'h123453B7;
        pc = 32'h304;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_ready", in_ready, 0);
            @(posedge clk);
            #1;
            chk("bp_valid", out_valid, 1);
            chk("bp_src2", src2, 5);
            chk("bp_pc", pc_q, 32'h300);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_rel_ready", in_ready, 1);
        @(posedge clk);
        #1;
        chk("bp_rel_src2", src2, 32'h12345000);
        chk("bp_rel_waddr", waddr, 7);

        // reset while the slot is held discards it
        out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_src2", src2, 0);
        chk("rst_mid_pc", pc_q, 0);

        // illegal opcode, sticky error across flush
        out_ready = 1'b1;
        instr = 32'h0000057F;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("ill_flag", illegal, 1);
        chk("ill_waddr", waddr, 0);
        chk("ill_err", error, 1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("ill_flush_valid", out_valid, 0);
        chk("ill_flush_ill", illegal, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("ill_err_sticky", error, 1);
        do_reset();
        chk("ill_err_rst", error, 0);

        // randomized run against the model
        for (int i = 1; i < 32; i++) regs[i] = $urandom;
        do_reset();
        m_valid = 0; m_ill = 0; m_err = 0; m_pc = 0;
        m_s1 = 0; m_s2 = 0; m_waddr = 0; m_op = RTLOP_ADD; m_cnt = 0;
        for (int c = 0; c < 2000; c++) begin
            instr = gen_instr();
            pc = $urandom;
            in_valid = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            flush = ($urandom_range(0, 19) == 0);
            for (int i = 0; i < NF; i++)
                set_fwd(i, 5'($urandom_range(0, 7)), $urandom,
                        $urandom_range(0, 3) == 0);
            #1;
            d  = ref_decode(instr);
            o1 = ref_operand(instr[19:15]);
            o2 = ref_operand(instr[24:20]);
            hz = in_valid && ((d.u1 && o1[32]) || (d.u2 && o2[32]));
            free = !m_valid || out_ready;
            rdy = free && !hz && !flush;
            chk("r_ready", in_ready, rdy);
            chk("r_raddr1", raddr1, instr[19:15]);
            chk("r_raddr2", raddr2, instr[24:20]);
            chk("r_valid", out_valid, m_valid);
            chk("r_ill", illegal, m_ill);
            chk("r_err", error, m_err);
            chk("r_cnt", stall_cnt, m_cnt);
            if (m_valid) begin
                chk("r_pc", pc_q, m_pc);
                chk("r_waddr", waddr, m_waddr);
                if (!m_ill) begin
                    chk("r_src1", src1, m_s1);
                    chk("r_src2", src2, m_s2);
                    chk("r_op", rtlop, m_op);
                    chk("r_type", rtltype, ref_type(m_op));
                end
            end
            @(posedge clk);
            if (flush) begin
                m_valid = 0;
                m_ill = 0;
            end else if (in_valid && rdy) begin
                m_valid = 1;
                m_ill = d.ill;
                m_pc = pc;
                m_op = d.op;
                m_waddr = d.ill ? 5'd0 : instr[11:7];
                m_s1 = (d.s1 == 0) ? o1[31:0] :
                       (d.s1 == 2) ? pc : 32'h0;
                m_s2 = d.u2 ? o2[31:0] : d.imm;
                if (d.ill) m_err = 1;
            end else if (free) begin
                m_valid = 0;
            end
            if (hz && !flush && m_cnt != 15) m_cnt++;
            #1;
        end
        in_valid = 1'b0;
        flush = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
